// File: rtl/sr_cmd_pkg.sv
// Shared types and constants for the SR flop command driver.
package sr_cmd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    GUARD = 2'd2
  } state_t;

  localparam logic OP_SET = 1'b1;
  localparam logic OP_RST = 1'b0;

endpackage

// File: rtl/sr_cmd_driver_sat_counter.sv
// Saturating up-counter: holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (inc && (cnt != {W{1'b1}})) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/sr_cmd_driver.sv
// Turns set/reset commands into exclusive timed s/r pulses plus a guard gap, then checks q.
// One command in flight; req_ready is low from accept until PULSE+GUARD cycles later.
module sr_cmd_driver
  import sr_cmd_pkg::*;
#(
  parameter int PULSE_CYCLES = 1,
  parameter int GUARD_CYCLES = 2,
  parameter int CNT_W        = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  input  logic             req_op,
  output logic             req_ready,
  input  logic             q,
  input  logic             err_clr,
  output logic             s,
  output logic             r,
  output logic             busy,
  output logic             err,
  output logic [CNT_W-1:0] set_cnt,
  output logic [CNT_W-1:0] rst_cnt
);

  localparam int TMAX = (PULSE_CYCLES > GUARD_CYCLES) ? PULSE_CYCLES : GUARD_CYCLES;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam logic [TW-1:0] PULSE_LD = TW'(PULSE_CYCLES - 1);
  localparam logic [TW-1:0] GUARD_LD = TW'(GUARD_CYCLES - 1);

  state_t        state, state_nxt;
  logic [TW-1:0] tmr, tmr_nxt;
  logic          op_q, op_nxt;
  logic          s_nxt, r_nxt, err_nxt;
  logic          accept, check;

  assign req_ready = (state == IDLE);
  assign busy      = ~req_ready;
  assign accept    = req_valid & req_ready;

  always_comb begin
    state_nxt = state;
    tmr_nxt   = tmr;
    op_nxt    = op_q;
    s_nxt     = 1'b0;
    r_nxt     = 1'b0;
    check     = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = DRIVE;
          op_nxt    = req_op;
          tmr_nxt   = PULSE_LD;
          s_nxt     = req_op;
          r_nxt     = ~req_op;
        end
      end
      DRIVE: begin
        if (tmr == '0) begin
          state_nxt = GUARD;
          tmr_nxt   = GUARD_LD;
        end else begin
          tmr_nxt = tmr - TW'(1);
          s_nxt   = op_q;
          r_nxt   = ~op_q;
        end
      end
      GUARD: begin
        if (tmr == '0) begin
          state_nxt = IDLE;
          check     = 1'b1;
        end else begin
          tmr_nxt = tmr - TW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // A mismatch on the check edge beats a simultaneous clear.
  always_comb begin
    err_nxt = err;
    if (err_clr) err_nxt = 1'b0;
    if (check && (q != op_q)) err_nxt = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      tmr   <= '0;
      op_q  <= OP_RST;
      s     <= 1'b0;
      r     <= 1'b0;
      err   <= 1'b0;
    end else begin
      state <= state_nxt;
      tmr   <= tmr_nxt;
      op_q  <= op_nxt;
      s     <= s_nxt;
      r     <= r_nxt;
      err   <= err_nxt;
    end
  end

  sat_counter #(.W(CNT_W)) u_set_cnt (
    .clk (clk),
    .rst (rst),
    .inc (accept && (req_op == OP_SET)),
    .cnt (set_cnt)
  );

  sat_counter #(.W(CNT_W)) u_rst_cnt (
    .clk (clk),
    .rst (rst),
    .inc (accept && (req_op == OP_RST)),
    .cnt (rst_cnt)
  );

endmodule

// File: tb/tb_sr_cmd_driver.sv
// Bench for sr_cmd_driver: default, long-pulse and narrow-counter instances.
module tb_sr_cmd_driver;

  localparam int PULSE_A = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Instance A: default timing, driven against a behavioural SR flop.
  logic       rst_a = 1'b0, valid_a = 1'b0, op_a = 1'b0, clr_a = 1'b0;
  logic       ready_a, s_a, r_a, busy_a, err_a, q_a;
  logic [7:0] setc_a, rstc_a;
  logic       q_ff = 1'b0, force_q0 = 1'b0;

  always @(posedge clk) begin
    if (s_a)      q_ff <= 1'b1;
    else if (r_a) q_ff <= 1'b0;
  end
  assign q_a = force_q0 ? 1'b0 : q_ff;

  sr_cmd_driver u_a (
    .clk(clk), .rst(rst_a), .req_valid(valid_a), .req_op(op_a), .req_ready(ready_a),
    .q(q_a), .err_clr(clr_a), .s(s_a), .r(r_a), .busy(busy_a), .err(err_a),
    .set_cnt(setc_a), .rst_cnt(rstc_a)
  );

  // Instance B: long pulse, short guard.
  logic       rst_bc = 1'b0, valid_b = 1'b0, op_b = 1'b0, clr_b = 1'b0, q_b = 1'b0;
  logic       ready_b, s_b, r_b, busy_b, err_b;
  logic [7:0] setc_b, rstc_b;

  sr_cmd_driver #(.PULSE_CYCLES(3), .GUARD_CYCLES(1)) u_b (
    .clk(clk), .rst(rst_bc), .req_valid(valid_b), .req_op(op_b), .req_ready(ready_b),
    .q(q_b), .err_clr(clr_b), .s(s_b), .r(r_b), .busy(busy_b), .err(err_b),
    .set_cnt(setc_b), .rst_cnt(rstc_b)
  );

  // Instance C: 2-bit counters for saturation.
  logic       valid_c = 1'b0, op_c = 1'b0, clr_c = 1'b0, q_c = 1'b1;
  logic       ready_c, s_c, r_c, busy_c, err_c;
  logic [1:0] setc_c, rstc_c;

  sr_cmd_driver #(.CNT_W(2)) u_c (
    .clk(clk), .rst(rst_bc), .req_valid(valid_c), .req_op(op_c), .req_ready(ready_c),
    .q(q_c), .err_clr(clr_c), .s(s_c), .r(r_c), .busy(busy_c), .err(err_c),
    .set_cnt(setc_c), .rst_cnt(rstc_c)
  );

  // Scoreboard: ops pushed on accept by the stimulus, popped when a pulse completes.
  logic exp_q[$];
  int   exp_set = 0, exp_rst = 0;
  int   acc_cnt_a = 0;
  int   plen = 0;
  logic pop_op = 1'b0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst_a && valid_a && ready_a) acc_cnt_a <= acc_cnt_a + 1;
  end

  always @(negedge clk) begin
    check("s_r_excl_a", 32'(s_a & r_a), 0);
    if (!rst_a) begin
      if (s_a | r_a) begin
        if (plen == 0) pop_op = s_a;
        plen++;
      end else if (plen != 0) begin
        if (exp_q.size() == 0) begin
          check("sb_underflow", exp_q.size(), 1);
        end else begin
          logic eop;
          eop = exp_q.pop_front();
          check("pulse_op", 32'(pop_op), 32'(eop));
          check("pulse_len", plen, PULSE_A);
        end
        plen = 0;
      end
    end
  end

  task automatic send_a(input logic op, output int n);
    @(negedge clk);
    check("ready_before_send", 32'(ready_a), 1);
    valid_a = 1'b1;
    op_a    = op;
    @(posedge clk);
    exp_q.push_back(op);
    if (op) exp_set++; else exp_rst++;
    @(negedge clk);
    valid_a = 1'b0;
    check("busy_after_accept", 32'(busy_a), 1);
    check("setcnt_next", 32'(setc_a), exp_set);
    check("rstcnt_next", 32'(rstc_a), exp_rst);
    n = 1;
    while (!ready_a && n < 50) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    int   n, w, acc0, exp_c;
    int   acc[3];
    logic [2:0] b2b_ops;

    #1;
    rst_a  = 1'b1;
    rst_bc = 1'b1;
    #3;
    check("rst_s", 32'(s_a), 0);
    check("rst_r", 32'(r_a), 0);
    check("rst_ready", 32'(ready_a), 1);
    check("rst_busy", 32'(busy_a), 0);
    check("rst_err", 32'(err_a), 0);
    check("rst_setcnt", 32'(setc_a), 0);
    check("rst_rstcnt", 32'(rstc_a), 0);
    @(negedge clk);
    @(negedge clk);
    rst_a  = 1'b0;
    rst_bc = 1'b0;

    // Reset, then set
    send_a(1'b1, n);
    check("set_ready_gap", n, 4);
    check("set_q", 32'(q_a), 1);
    check("set_err", 32'(err_a), 0);
    check("set_setcnt", 32'(setc_a), 1);

    // Back-to-back with valid held high
    b2b_ops = 3'b101;
    acc0 = acc_cnt_a;
    @(negedge clk);
    valid_a = 1'b1;
    for (int i = 0; i < 3; i++) begin
      w = 0;
      while (!ready_a && w < 50) begin
        @(negedge clk);
        w++;
      end
      op_a = b2b_ops[i];
      @(posedge clk);
      exp_q.push_back(b2b_ops[i]);
      if (b2b_ops[i]) exp_set++; else exp_rst++;
      @(negedge clk);
      acc[i] = cyc;
    end
    valid_a = 1'b0;
    repeat (6) @(negedge clk);
    check("b2b_accepts", acc_cnt_a - acc0, 3);
    check("b2b_gap1", acc[1] - acc[0], 4);
    check("b2b_gap2", acc[2] - acc[1], 4);
    check("b2b_setcnt", 32'(setc_a), exp_set);
    check("b2b_rstcnt", 32'(rstc_a), exp_rst);

    // Error path
    force_q0 = 1'b1;
    send_a(1'b1, n);
    check("err_set", 32'(err_a), 1);
    force_q0 = 1'b0;
    clr_a = 1'b1;
    @(negedge clk);
    clr_a = 1'b0;
    check("err_clr", 32'(err_a), 0);
    force_q0 = 1'b1;
    clr_a = 1'b1;
    send_a(1'b1, n);
    check("err_set_beats_clr", 32'(err_a), 1);
    force_q0 = 1'b0;
    @(negedge clk);
    clr_a = 1'b0;
    check("err_clr2", 32'(err_a), 0);
    send_a(1'b0, n);
    check("match_no_err", 32'(err_a), 0);
    check("q_after_reset_cmd", 32'(q_a), 0);

    // Reset mid-command
    @(negedge clk);
    valid_a = 1'b1;
    op_a    = 1'b1;
    @(posedge clk);
    #2;
    rst_a   = 1'b1;
    valid_a = 1'b0;
    exp_q.delete();
    exp_set = 0;
    exp_rst = 0;
    #1;
    check("mid_s", 32'(s_a), 0);
    check("mid_r", 32'(r_a), 0);
    check("mid_ready", 32'(ready_a), 1);
    check("mid_busy", 32'(busy_a), 0);
    check("mid_err", 32'(err_a), 0);
    check("mid_setcnt", 32'(setc_a), 0);
    @(negedge clk);
    @(negedge clk);
    rst_a = 1'b0;
    check("q_untouched", 32'(q_a), 0);
    send_a(1'b1, n);
    check("post_rst_gap", n, 4);
    check("post_rst_q", 32'(q_a), 1);
    check("post_rst_setcnt", 32'(setc_a), 1);
    check("post_rst_err", 32'(err_a), 0);

    // Long pulse on instance B
    @(negedge clk);
    valid_b = 1'b1;
    op_b    = 1'b0;
    @(posedge clk);
    @(negedge clk);
    valid_b = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      check("long_r", 32'(r_b), 32'(i <= 3));
      check("long_s", 32'(s_b), 0);
      check("long_ready", 32'(ready_b), 32'(i == 5));
      if (i < 5) @(negedge clk);
    end
    check("long_rstcnt", 32'(rstc_b), 1);
    check("long_err", 32'(err_b), 0);

    // Saturation on instance C
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      valid_c = 1'b1;
      op_c    = 1'b1;
      @(posedge clk);
      @(negedge clk);
      valid_c = 1'b0;
      w = 1;
      while (!ready_c && w < 50) begin
        @(negedge clk);
        w++;
      end
      exp_c = (i > 3) ? 3 : i;
      check("sat_setcnt", 32'(setc_c), exp_c);
    end

    repeat (3) @(negedge clk);
    check("sb_drain", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
